code_sequencer: RTL

- Sequences the datapath's code storage and fetch stages.
- Accepts a program as a valid/ready stream of 12-bit instruction words and drives the code storage write interface to store them at consecutive lines.
- On start, pulses the code-control reset, asserts active for the run, and watches the parse op and fetch code index to decide when execution ends.
- Sits between the host/loader and the datapath's code_storage write and code-control interfaces.

---
 rtl/code_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/code_sequencer.sv
// code_sequencer: loads a program into code storage from a valid/ready word
// stream, then runs it by driving the code-control reset/active pair until
// the parse stage reports the halt op or fetch runs past the program.
module code_sequencer #(
  parameter int unsigned     LINE_W    = 32,
  parameter int unsigned     DATA_W    = 12,
  parameter int unsigned     OP_W      = 4,
  parameter logic [OP_W-1:0] HALT_OP   = 4'hF,
  parameter int unsigned     MAX_LINES = 1024
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  // host program stream
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  // run control
  input  logic              start,
  input  logic              abort,
  // datapath observation
  input  logic [OP_W-1:0]   op_in,
  input  logic [LINE_W-1:0] code_index_in,
  // code storage write port
  output logic [LINE_W-1:0] write_line,
  output logic [DATA_W-1:0] write_data,
  output logic              is_write,
  // code-control
  output logic              code_reset,
  output logic              code_active,
  // status
  output logic              program_loaded,
  output logic [LINE_W-1:0] line_count,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [31:0]       run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(MAX_LINES - 1);
  localparam logic [LINE_W-1:0] LINE_CAP  = LINE_W'(MAX_LINES);

  state_t            state;
  state_t            state_next;
  logic [LINE_W-1:0] ptr;          // next line to write inside a program
  logic [LINE_W-1:0] wr_line;      // line the word offered now would land on
  logic              accept;       // word handshake completes this cycle
  logic              take;         // accepted word is actually stored
  logic              at_cap;       // offered word lands on the last line
  logic              run_end;      // execution has reached its end condition

  // A word arriving in IDLE always begins a fresh program at line 0.
  assign load_ready = ((state == S_IDLE) && !start) || (state == S_LOAD);
  assign accept     = load_valid && load_ready;
  assign take       = accept && !abort;
  assign wr_line    = (state == S_IDLE) ? '0 : ptr;
  assign at_cap     = (wr_line == LAST_LINE);
  assign run_end    = (op_in == HALT_OP) || (code_index_in >= line_count);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= S_IDLE;
    else                state <= state_next;
  end

  // Next-state decode; abort overrides every other transition.
  // NOTE: state_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (program_loaded) state_next = S_CLEAR;
          end else if (accept && !load_last && !at_cap) begin
            state_next = S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept && (load_last || at_cap)) state_next = S_IDLE;
        end
        S_CLEAR: state_next = S_RUN;
        S_RUN: begin
          if (run_end) state_next = S_DONE;
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Code-control and status strobes, registered against the upcoming state.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      code_reset  <= 1'b0;
      code_active <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      code_reset  <= (state_next == S_CLEAR);
      code_active <= (state_next == S_RUN);
      done        <= (state_next == S_DONE);
      busy        <= (state_next != S_IDLE);
    end
  end

  // Code storage write port; line/data hold when no word is stored.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      is_write   <= 1'b0;
      write_line <= '0;
      write_data <= '0;
      ptr        <= '0;
    end else begin
      is_write <= take;
      if (take) begin
        write_line <= wr_line;
        write_data <= load_data;
        ptr        <= wr_line + LINE_W'(1);
      end
    end
  end

  // Resident-program bookkeeping: completion, overflow and abort discard.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      program_loaded <= 1'b0;
      line_count     <= '0;
      overflow       <= 1'b0;
    end else if (abort) begin
      if (state == S_LOAD) begin
        program_loaded <= 1'b0;
        line_count     <= '0;
      end
    end else if (accept) begin
      if (load_last) begin
        program_loaded <= 1'b1;
        line_count     <= wr_line + LINE_W'(1);
        overflow       <= (state == S_IDLE) ? 1'b0 : overflow;
      end else if (at_cap) begin
        program_loaded <= 1'b1;
        line_count     <= LINE_CAP;
        overflow       <= 1'b1;
      end else if (state == S_IDLE) begin
        program_loaded <= 1'b0;
        line_count     <= '0;
        overflow       <= 1'b0;
      end
    end
  end

  // Run-length counter: cleared on launch, counts RUN cycles, saturates.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      run_cycles <= '0;
    end else if ((state == S_IDLE) && (state_next == S_CLEAR)) begin
      run_cycles <= '0;
    end else if ((state == S_RUN) && (run_cycles != 32'hFFFF_FFFF)) begin
      run_cycles <= run_cycles + 32'd1;
    end
  end

endmodule
